preproc_axil_regs: RTL and testbench

PREPROC_AXIL_REGS -- requirements
Module: preproc_axil_regs

---
 rtl/preproc_axil_regs.sv | 107 ++++++++++
 tb/tb_preproc_axil_regs.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preproc_axil_regs.sv
// preproc_axil_regs: AXI4-Lite control/status registers for the ADC preprocessing datapath.
module preproc_axil_regs #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int WSTRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic [WSTRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [15:0]            offset_o,
  output logic [4:0]             sel_source_o,
  output logic                   enable_o,
  input  logic                   sat_i
);
  logic                  r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic [1:0]            r_aw_addr, r_w_strb;
  logic [15:0]           r_w_data, r_offset, r_cnt;
  logic [4:0]            r_sel;
  logic                  r_en, r_sticky;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_wr, w_clr, w_unused;
  logic [1:0]            w_addr, w_strb;
  logic [15:0]           w_data;
  logic [DATA_WIDTH-1:0] w_rd;
  assign s_axi_awready = s_axi_aresetn && !r_aw_held && !r_bvalid;
  assign s_axi_wready  = s_axi_aresetn && !r_w_held && !r_bvalid;
  assign s_axi_arready = s_axi_aresetn && !r_rvalid;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign offset_o      = r_offset;
  assign sel_source_o  = r_sel;
  assign enable_o      = r_en;
  assign w_unused = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:16], s_axi_wstrb[3:2]};
  // A channel handshaking this cycle bypasses its holding register so the write commits on the same edge.
  always_comb begin
    w_aw_hs = s_axi_awvalid && s_axi_awready;
    w_w_hs  = s_axi_wvalid && s_axi_wready;
    w_ar_hs = s_axi_arvalid && s_axi_arready;
    w_wr    = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;
    w_addr  = r_aw_held ? r_aw_addr : s_axi_awaddr[3:2];
    w_data  = r_w_held ? r_w_data : s_axi_wdata[15:0];
    w_strb  = r_w_held ? r_w_strb : s_axi_wstrb[1:0];
    w_clr   = w_wr && w_addr == 2'd3 && w_data[0] && w_strb[0];
    w_rd    = s_axi_araddr[3:2] == 2'd0 ? {16'h0, r_offset} :
              s_axi_araddr[3:2] == 2'd1 ? {27'h0, r_sel} :
              s_axi_araddr[3:2] == 2'd2 ? {31'h0, r_en} : {r_cnt, 15'h0, r_sticky};
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= 2'd0;
      r_w_data  <= 16'h0;
      r_w_strb  <= 2'd0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_offset  <= 16'h0;
      r_sel     <= 5'h0;
      r_en      <= 1'b0;
      r_sticky  <= 1'b0;
      r_cnt     <= 16'h0;
    end else begin
      r_aw_held <= !w_wr && (r_aw_held || w_aw_hs);
      r_w_held  <= !w_wr && (r_w_held || w_w_hs);
      if (w_aw_hs) r_aw_addr <= s_axi_awaddr[3:2];
      if (w_w_hs) begin
        r_w_data <= s_axi_wdata[15:0];
        r_w_strb <= s_axi_wstrb[1:0];
      end
      r_bvalid <= w_wr || (r_bvalid && !s_axi_bready);
      r_rvalid <= w_ar_hs || (r_rvalid && !s_axi_rready);
      if (w_ar_hs) r_rdata <= w_rd;
      if (w_wr && w_addr == 2'd0) r_offset <= {w_strb[1] ? w_data[15:8] : r_offset[15:8],
                                               w_strb[0] ? w_data[7:0] : r_offset[7:0]};
      if (w_wr && w_addr == 2'd1 && w_strb[0]) r_sel <= w_data[4:0];
      if (w_wr && w_addr == 2'd2 && w_strb[0]) r_en <= w_data[0];
      // A saturation event in the clearing cycle wins and counts as the first event.
      if (sat_i) begin
        r_sticky <= 1'b1;
        r_cnt    <= w_clr ? 16'd1 : &r_cnt ? r_cnt : r_cnt + 16'd1;
      end else if (w_clr) begin
        r_sticky <= 1'b0;
        r_cnt    <= 16'h0;
      end
    end
  end
endmodule

// File: tb/tb_preproc_axil_regs.sv
// tb_preproc_axil_regs: directed self-checking bench for preproc_axil_regs.
module tb_preproc_axil_regs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, sat_i = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, enable_o;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] offset_o;
  logic [4:0]  sel_source_o;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  preproc_axil_regs dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .offset_o(offset_o), .sel_source_o(sel_source_o), .enable_o(enable_o), .sat_i(sat_i)
  );

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic ok);
    bit ad = 0, wd = 0;
    int n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    while (!(ad && wd) && n < 20) begin
      if (awvalid && awready) ad = 1;
      if (wvalid && wready) wd = 1;
      @(negedge clk);
      if (ad) awvalid = 0;
      if (wd) wvalid = 0;
      n++;
    end
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = bvalid && ad && wd;
    resp = bresp;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic ok);
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = rvalid;
    d = rdata;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic test_reset;
    #2;
    n_chk++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {awready, wready, arready, bvalid, rvalid});
    end
    n_chk++;
    if ({rdata, offset_o, sel_source_o, enable_o, bresp, rresp} !== 58'h0) begin
      n_fail++; $display("FAIL reset_data: rdata=%h offset=%h sel=%h en=%b", rdata, offset_o, sel_source_o, enable_o);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1;
    n_chk++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_same_cycle;
    logic [31:0] d; logic ok;
    @(negedge clk);
    awaddr = 4'h0; wdata = 32'h0000_8123; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    n_chk++;
    if ({bvalid, bresp} !== 3'b100 || offset_o !== 16'h8123) begin
      n_fail++; $display("FAIL same_cycle_write: bvalid=%b bresp=%b offset=%h want 1 00 8123", bvalid, bresp, offset_o);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    n_chk++;
    if (bvalid !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_bclear: bvalid=%b want 0", bvalid);
    end
    do_read(4'h0, d, ok);
    n_chk++;
    if (!ok || d !== 32'h0000_8123 || rresp !== 2'b00) begin
      n_fail++; $display("FAIL same_cycle_read: ok=%b rdata=%h want 00008123", ok, d);
    end
  endtask

  task automatic test_w_before_aw;
    @(negedge clk);
    wdata = 32'h1F; wstrb = 4'hF; wvalid = 1; bready = 0;
    @(negedge clk);
    wvalid = 0;
    n_chk++;
    if ({wready, awready, bvalid} !== 3'b010) begin
      n_fail++; $display("FAIL w_held: wready/awready/bvalid=%b want 010", {wready, awready, bvalid});
    end
    @(negedge clk);
    awaddr = 4'h4; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({bvalid, awready, wready} !== 3'b100 || sel_source_o !== 5'h1F) begin
        n_fail++; $display("FAIL w_before_aw_hold%0d: bvalid/awready/wready=%b sel=%h want 100 1f", i, {bvalid, awready, wready}, sel_source_o);
      end
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    n_chk++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_fail++; $display("FAIL w_before_aw_release: bvalid/awready/wready=%b want 011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_strobe;
    logic [31:0] d; logic [1:0] r; logic ok;
    do_write(4'h0, 32'hFFFF_FFFF, 4'b0010, r, ok);
    n_chk++;
    if (!ok || r !== 2'b00 || offset_o !== 16'hFF23) begin
      n_fail++; $display("FAIL strobe_offset: ok=%b offset=%h want ff23", ok, offset_o);
    end
    do_read(4'h0, d, ok);
    n_chk++;
    if (!ok || d !== 32'h0000_FF23) begin
      n_fail++; $display("FAIL strobe_read: rdata=%h want 0000ff23", d);
    end
    do_write(4'h4, 32'h0, 4'b0000, r, ok);
    n_chk++;
    if (!ok || r !== 2'b00 || sel_source_o !== 5'h1F) begin
      n_fail++; $display("FAIL strobe_zero: ok=%b bresp=%b sel=%h want 1 00 1f", ok, r, sel_source_o);
    end
    do_read(4'h4, d, ok);
    n_chk++;
    if (!ok || d !== 32'h0000_001F) begin
      n_fail++; $display("FAIL sel_read: rdata=%h want 0000001f", d);
    end
  endtask

  task automatic test_sat;
    logic [31:0] d; logic [1:0] r; logic ok;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); sat_i = 1;
      @(negedge clk); sat_i = 0;
    end
    do_read(4'hC, d, ok);
    n_chk++;
    if (!ok || d !== 32'h0003_0001) begin
      n_fail++; $display("FAIL sat_count3: rdata=%h want 00030001", d);
    end
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1; sat_i = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; sat_i = 0;
    @(negedge clk);
    bready = 0;
    do_read(4'hC, d, ok);
    n_chk++;
    if (!ok || d !== 32'h0001_0001) begin
      n_fail++; $display("FAIL sat_clear_set_wins: rdata=%h want 00010001", d);
    end
    do_write(4'hC, 32'h1, 4'hE, r, ok);
    do_read(4'hC, d, ok);
    n_chk++;
    if (!ok || d !== 32'h0001_0001) begin
      n_fail++; $display("FAIL sat_no_clear_lane0_off: rdata=%h want 00010001", d);
    end
    do_write(4'hC, 32'h1, 4'h1, r, ok);
    do_read(4'hC, d, ok);
    n_chk++;
    if (!ok || d !== 32'h0) begin
      n_fail++; $display("FAIL sat_clear: rdata=%h want 00000000", d);
    end
  endtask

  task automatic test_read_hold;
    logic [31:0] d; logic ok;
    @(negedge clk);
    araddr = 4'h8; arvalid = 1; rready = 0;
    @(negedge clk);
    arvalid = 0;
    awaddr = 4'h8; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      n_chk++;
      if (rvalid !== 1'b1 || rdata !== 32'h0 || arready !== 1'b0) begin
        n_fail++; $display("FAIL read_hold%0d: rvalid=%b rdata=%h arready=%b want 1 0 0", i, rvalid, rdata, arready);
      end
    end
    bready = 0;
    n_chk++;
    if (enable_o !== 1'b1) begin
      n_fail++; $display("FAIL enable_set: enable=%b want 1", enable_o);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    n_chk++;
    if (rvalid !== 1'b0) begin
      n_fail++; $display("FAIL read_release: rvalid=%b want 0", rvalid);
    end
    do_read(4'h8, d, ok);
    n_chk++;
    if (!ok || d !== 32'h1) begin
      n_fail++; $display("FAIL enable_read: rdata=%h want 00000001", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic ok;
    @(negedge clk);
    awaddr = 4'h0; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    araddr = 4'h0; arvalid = 1; rready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    n_chk++;
    if ({bvalid, rvalid} !== 2'b11 || rdata !== 32'h0000_FF23 || offset_o !== 16'h0005) begin
      n_fail++; $display("FAIL rw_collision: bv/rv=%b rdata=%h offset=%h want 11 0000ff23 0005", {bvalid, rvalid}, rdata, offset_o);
    end
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b0 ||
        {rdata, offset_o, sel_source_o, enable_o} !== 54'h0) begin
      n_fail++; $display("FAIL reset_mid: bv/rv/aw/w/ar=%b rdata=%h offset=%h sel=%h en=%b",
                         {bvalid, rvalid, awready, wready, arready}, rdata, offset_o, sel_source_o, enable_o);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_chk++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_mid_ready: got %b want 111", {awready, wready, arready});
    end
    bready = 1; rready = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bvalid, rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_no_resp: bv/rv=%b want 00", {bvalid, rvalid});
    end
    bready = 0; rready = 0;
    do_read(4'h4, d, ok);
    n_chk++;
    if (!ok || d !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_sel: rdata=%h want 00000000", d);
    end
  endtask

  initial begin
    test_reset;
    test_same_cycle;
    test_w_before_aw;
    test_strobe;
    test_sat;
    test_read_hold;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
